// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit serializer.
// Break-state encodings exist only when UART_TX_BREAK_EN is defined.
package uart_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_ODD  = 2'b01;
   localparam logic [1:0] PAR_EVEN = 2'b10;
   localparam logic [1:0] PAR_MARK = 2'b11;

   localparam int MIN_DATA_W = 5;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
`ifdef UART_TX_BREAK_EN
      ST_STOP2  = 3'd5,
      ST_BREAK  = 3'd6,
      ST_BRK_MK = 3'd7
`else
      ST_STOP2  = 3'd5
`endif
   } tx_state_t;

   function automatic logic [3:0] clamp_len(
      input logic [3:0] len,
      input int         max_w
   );
      if (int'(len) < MIN_DATA_W) return 4'(MIN_DATA_W);
      if (int'(len) > max_w)      return 4'(max_w);
      return len;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous word FIFO feeding the UART serializer.
// Same-cycle push and pop are both honoured; push is ignored when full.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 9
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [W-1:0]                   din,
   input  logic                           pop,
   output logic [W-1:0]                   dout,
   output logic                           full,
   output logic                           empty,
   output logic [$clog2(DEPTH+1)-1:0]     level
);
   import uart_pkg::*;

   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      level <= level + LW'(1);
         else if (!do_push && do_pop) level <= level - LW'(1);
      end
   end

   // Storage array, written on accepted pushes
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmit engine: FIFO-buffered words serialised one bit per baud_clk.
// Define UART_TX_BREAK_EN to add the break_req port and break states.
module uart_tx_serializer #(
   parameter int MAX_DATA_W = 9,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                              baud_clk,
   input  logic                              rst,
`ifdef UART_TX_BREAK_EN
   input  logic                              break_req,
`endif
   input  logic [3:0]                        cfg_data_len,
   input  logic [1:0]                        cfg_parity,
   input  logic                              cfg_stop2,
   input  logic                              s_valid,
   output logic                              s_ready,
   input  logic [MAX_DATA_W-1:0]             s_data,
   output logic                              tx,
   output logic                              tx_active,
   output logic                              tx_done,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level
);
   import uart_pkg::*;

   tx_state_t             state;
   logic [MAX_DATA_W-1:0] shreg;
   logic [3:0]            bit_cnt;
   logic                  par_acc;
   logic [3:0]            len_q;
   logic [1:0]            par_q;
   logic                  stop2_q;

   logic [MAX_DATA_W-1:0] fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  push;
   logic                  frame_end;
   logic                  start_frame;
   logic                  brk;

`ifdef UART_TX_BREAK_EN
   logic                  mark_cnt;
   assign brk = break_req;
`else
   assign brk = 1'b0;
`endif

   assign s_ready     = !fifo_full;
   assign push        = s_valid && s_ready;
   assign frame_end   = (state == ST_STOP1 && !stop2_q) ||
                        (state == ST_STOP2);
   assign start_frame = !fifo_empty &&
                        ((state == ST_IDLE && !brk) || frame_end);

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (MAX_DATA_W)
   ) u_fifo (
      .clk   (baud_clk),
      .rst   (rst),
      .push  (push),
      .din   (s_data),
      .pop   (start_frame),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   // Frame FSM; line outputs are registered from the current state
   always_ff @(posedge baud_clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         tx        <= 1'b1;
         tx_active <= 1'b0;
         tx_done   <= 1'b0;
         shreg     <= '0;
         bit_cnt   <= '0;
         par_acc   <= 1'b0;
         len_q     <= 4'(MIN_DATA_W);
         par_q     <= PAR_NONE;
         stop2_q   <= 1'b0;
`ifdef UART_TX_BREAK_EN
         mark_cnt  <= 1'b0;
`endif
      end else begin
         tx_done <= 1'b0;
         if (start_frame) begin
            shreg   <= fifo_dout;
            par_acc <= 1'b0;
            len_q   <= clamp_len(cfg_data_len, MAX_DATA_W);
            par_q   <= cfg_parity;
            stop2_q <= cfg_stop2;
         end
         unique case (state)
            ST_IDLE: begin
               tx        <= 1'b1;
               tx_active <= 1'b0;
               if (brk)              state <= tx_state_t'(3'd6);
               else if (start_frame) state <= ST_START;
            end
            ST_START: begin
               tx        <= 1'b0;
               tx_active <= 1'b1;
               bit_cnt   <= '0;
               state     <= ST_DATA;
            end
            ST_DATA: begin
               tx        <= shreg[0];
               tx_active <= 1'b1;
               shreg     <= shreg >> 1;
               par_acc   <= par_acc ^ shreg[0];
               bit_cnt   <= bit_cnt + 4'd1;
               if (bit_cnt == len_q - 4'd1) begin
                  state <= (par_q != PAR_NONE) ? ST_PARITY : ST_STOP1;
               end
            end
            ST_PARITY: begin
               tx_active <= 1'b1;
               case (par_q)
                  PAR_ODD:  tx <= ~par_acc;
                  PAR_EVEN: tx <= par_acc;
                  default:  tx <= 1'b1;
               endcase
               state <= ST_STOP1;
            end
            ST_STOP1: begin
               tx        <= 1'b1;
               tx_active <= 1'b1;
               if (stop2_q) begin
                  state <= ST_STOP2;
               end else begin
                  tx_done <= 1'b1;
                  state   <= start_frame ? ST_START : ST_IDLE;
               end
            end
            ST_STOP2: begin
               tx        <= 1'b1;
               tx_active <= 1'b1;
               tx_done   <= 1'b1;
               state     <= start_frame ? ST_START : ST_IDLE;
            end
`ifdef UART_TX_BREAK_EN
            ST_BREAK: begin
               tx        <= 1'b0;
               tx_active <= 1'b1;
               mark_cnt  <= 1'b0;
               if (!brk) state <= ST_BRK_MK;
            end
            ST_BRK_MK: begin
               tx        <= 1'b1;
               tx_active <= 1'b1;
               mark_cnt  <= 1'b1;
               if (mark_cnt) state <= ST_IDLE;
            end
`endif
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer.
// Break scenario is exercised only when UART_TX_BREAK_EN is defined.
module tb_uart_tx_serializer;

   localparam int MW = 9;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [3:0]    cfg_data_len;
   logic [1:0]    cfg_parity;
   logic          cfg_stop2;
   logic          s_valid;
   logic          s_ready;
   logic [MW-1:0] s_data;
   logic          tx;
   logic          tx_active;
   logic          tx_done;
   logic [2:0]    fifo_level;
`ifdef UART_TX_BREAK_EN
   logic          break_req;
`endif

   int tests = 0;
   int fails = 0;

   logic [1:0] exp_q[$];
   bit  mon_en = 1'b0;
   bit  prev_act = 1'b0;
   int  act_cycles = 0;
   int  done_cnt = 0;
   int  act_falls = 0;

   always #5 clk = ~clk;

   uart_tx_serializer #(
      .MAX_DATA_W (MW),
      .FIFO_DEPTH (FD)
   ) dut (
      .baud_clk     (clk),
      .rst          (rst),
`ifdef UART_TX_BREAK_EN
      .break_req    (break_req),
`endif
      .cfg_data_len (cfg_data_len),
      .cfg_parity   (cfg_parity),
      .cfg_stop2    (cfg_stop2),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .tx           (tx),
      .tx_active    (tx_active),
      .tx_done      (tx_done),
      .fifo_level   (fifo_level)
   );

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected frame for word w under the config currently driven
   task automatic add_frame(input logic [MW-1:0] w);
      int  len;
      logic p;
      len = int'(cfg_data_len);
      if (len < 5)  len = 5;
      if (len > MW) len = MW;
      p = 1'b0;
      exp_q.push_back(2'b00);
      for (int i = 0; i < len; i++) begin
         exp_q.push_back({1'b0, w[i]});
         p = p ^ w[i];
      end
      if (cfg_parity == 2'b01) exp_q.push_back({1'b0, ~p});
      if (cfg_parity == 2'b10) exp_q.push_back({1'b0, p});
      if (cfg_parity == 2'b11) exp_q.push_back(2'b01);
      if (cfg_stop2) begin
         exp_q.push_back(2'b01);
         exp_q.push_back(2'b11);
      end else begin
         exp_q.push_back(2'b11);
      end
   endtask

   task automatic push_word(input logic [MW-1:0] w);
      int n = 0;
      @(negedge clk);
      while (!s_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (n >= 200) check("push_timeout", 32'(n), 32'(0));
      s_valid = 1'b1;
      s_data  = w;
      add_frame(w);
      @(posedge clk);
      #1 s_valid = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      @(negedge clk);
      while ((tx_active || fifo_level != 0 || exp_q.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_timeout"}, 32'(n < 1000), 32'(1));
      check({tag, "_sb_empty"}, 32'(exp_q.size()), 32'(0));
   endtask

   task automatic clr_stats();
      act_cycles = 0;
      done_cnt   = 0;
      act_falls  = 0;
   endtask

   // Scoreboard monitor: every active cycle pops one expected line bit
   always @(negedge clk) begin
      logic [1:0] e;
      if (mon_en && !rst) begin
         if (tx_active) begin
            act_cycles++;
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(1), 32'(0));
            end else begin
               e = exp_q.pop_front();
               check("tx_bit", 32'(tx), 32'(e[0]));
               check("tx_done", 32'(tx_done), 32'(e[1]));
            end
         end else begin
            check("idle_tx", 32'(tx), 32'(1));
         end
         if (tx_done) done_cnt++;
         if (prev_act && !tx_active) act_falls++;
         prev_act = tx_active;
      end
   end

   initial begin
`ifdef UART_TX_BREAK_EN
      logic rec [60];
      int   idx;
      int   z0;
      int   o1;
      break_req = 1'b0;
`endif
      rst          = 1'b1;
      s_valid      = 1'b0;
      s_data       = '0;
      cfg_data_len = 4'd8;
      cfg_parity   = 2'b00;
      cfg_stop2    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx), 32'(1));
      check("rst_active", 32'(tx_active), 32'(0));
      check("rst_done", 32'(tx_done), 32'(0));
      check("rst_level", 32'(fifo_level), 32'(0));
      check("rst_ready", 32'(s_ready), 32'(1));
      rst = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      // 8N1 0xA5 with start-bit latency
      clr_stats();
      push_word(9'h0A5);
      check("lat_level", 32'(fifo_level), 32'(1));
      @(posedge clk);
      #1 check("lat_k1_tx", 32'(tx), 32'(1));
      @(posedge clk);
      #1 check("lat_k2_tx", 32'(tx), 32'(0));
      wait_idle("8n1");
      check("8n1_len", 32'(act_cycles), 32'(10));
      check("8n1_dones", 32'(done_cnt), 32'(1));

      // 7E2 0x55
      clr_stats();
      cfg_data_len = 4'd7;
      cfg_parity   = 2'b10;
      cfg_stop2    = 1'b1;
      push_word(9'h055);
      wait_idle("7e2");
      check("7e2_len", 32'(act_cycles), 32'(11));

      // 9O1 0x1FF
      clr_stats();
      cfg_data_len = 4'd9;
      cfg_parity   = 2'b01;
      cfg_stop2    = 1'b0;
      push_word(9'h1FF);
      wait_idle("9o1");
      check("9o1_len", 32'(act_cycles), 32'(12));

      // 8-bit mark parity
      clr_stats();
      cfg_data_len = 4'd8;
      cfg_parity   = 2'b11;
      push_word(9'h000);
      wait_idle("8m1");
      check("8m1_len", 32'(act_cycles), 32'(11));

      // Length clamping: 2 -> 5 with even parity, 15 -> 9 with 2 stops
      clr_stats();
      cfg_data_len = 4'd2;
      cfg_parity   = 2'b10;
      push_word(9'h1F3);
      wait_idle("clamp_lo");
      check("clamp_lo_len", 32'(act_cycles), 32'(8));
      clr_stats();
      cfg_data_len = 4'd15;
      cfg_parity   = 2'b00;
      cfg_stop2    = 1'b1;
      push_word(9'h16B);
      wait_idle("clamp_hi");
      check("clamp_hi_len", 32'(act_cycles), 32'(12));

      // Five words back-to-back, 8N1
      clr_stats();
      cfg_data_len = 4'd8;
      cfg_stop2    = 1'b0;
      push_word(9'h011);
      push_word(9'h0E2);
      push_word(9'h033);
      push_word(9'h0C4);
      push_word(9'h055);
      check("b2b_level", 32'(fifo_level), 32'(4));
      check("b2b_ready", 32'(s_ready), 32'(0));
      wait_idle("b2b");
      check("b2b_len", 32'(act_cycles), 32'(50));
      check("b2b_dones", 32'(done_cnt), 32'(5));
      check("b2b_gaps", 32'(act_falls), 32'(1));

      // Config change mid-frame only affects the next frame
      clr_stats();
      push_word(9'h03C);
      @(posedge clk);
      @(posedge clk);
      #1 check("cfg_mid_active", 32'(tx_active), 32'(1));
      cfg_data_len = 4'd5;
      push_word(9'h013);
      wait_idle("cfg_mid");
      check("cfg_mid_len", 32'(act_cycles), 32'(17));
      check("cfg_mid_dones", 32'(done_cnt), 32'(2));

      // Reset in the middle of DATA
      cfg_data_len = 4'd8;
      push_word(9'h0FF);
      push_word(9'h00F);
      repeat (5) @(posedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      check("mid_rst_tx", 32'(tx), 32'(1));
      check("mid_rst_level", 32'(fifo_level), 32'(0));
      check("mid_rst_ready", 32'(s_ready), 32'(1));
      check("mid_rst_active", 32'(tx_active), 32'(0));
      rst = 1'b0;
      exp_q.delete();
      @(negedge clk);
      prev_act = 1'b0;
      mon_en   = 1'b1;
      clr_stats();
      push_word(9'h05A);
      wait_idle("post_rst");
      check("post_rst_len", 32'(act_cycles), 32'(10));

`ifdef UART_TX_BREAK_EN
      // Break held 20 cycles with a word queued behind it
      mon_en = 1'b0;
      @(negedge clk);
      break_req = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 2) begin
            s_valid = 1'b1;
            s_data  = 9'h0AA;
         end
         if (i == 3)  s_valid = 1'b0;
         if (i == 19) break_req = 1'b0;
         rec[i] = tx;
      end
      idx = 0;
      while (idx < 60 && rec[idx] == 1'b1) idx++;
      z0 = 0;
      while (idx < 60 && rec[idx] == 1'b0) begin
         z0++;
         idx++;
      end
      o1 = 0;
      while (idx < 60 && rec[idx] == 1'b1) begin
         o1++;
         idx++;
      end
      check("brk_low_cycles", 32'(z0), 32'(20));
      check("brk_mark_min", 32'(o1 >= 2), 32'(1));
      check("brk_word_start", 32'(idx < 60), 32'(1));
      repeat (20) @(negedge clk);
      check("brk_drained", 32'(fifo_level), 32'(0));
      prev_act = tx_active;
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
